cr_huf_comp_htb_short_ord: RTL
==============================

CR_HUF_COMP_HTB_SHORT_ORD -- requirements
Module: cr_huf_comp_htb_short_ord

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of the per-block tree result payload.
REQ-002 SHALL have parameter ORD_DEPTH, default 4, dispatch-order FIFO depth (power of 2, >=2).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port disp_vld, input, 1, a short block was dispatched to a tree-builder pipe this cycle.
REQ-006 SHALL have port disp_pipe, input, 1, dispatch target: 0 = pipe 1, 1 = pipe 2.
REQ-007 SHALL have port disp_seq_id, input, `CREOLE_HC_SEQID_WIDTH, seq_id of the dispatched block.
REQ-008 SHALL have port ord_full, output, 1, order FIFO holds ORD_DEPTH entries.
REQ-009 SHALL have ports p1_vld in 1, p1_rdy out 1, p1_seq_id in `CREOLE_HC_SEQID_WIDTH, p1_data in DATA_W: pipe 1 result stream.
REQ-010 SHALL have ports p2_vld, p2_rdy, p2_seq_id, p2_data, identical to REQ-009 for pipe 2.
REQ-011 SHALL have ports out_vld out 1, out_rdy in 1, out_seq_id out `CREOLE_HC_SEQID_WIDTH, out_data out DATA_W, out_pipe out 1: in-order merged result stream.
REQ-012 SHALL have port seq_err, output, 1, sticky ordering/protocol error flag.

Function
REQ-013 SHALL record each accepted dispatch (disp_vld && !ord_full) as {disp_pipe, disp_seq_id} in the order FIFO.
REQ-014 SHALL drop disp_vld while ord_full is high; FIFO contents and count unchanged.
REQ-015 SHALL compute ord_full combinationally as count == ORD_DEPTH; count width clog2(ORD_DEPTH)+1; read/write pointers wrap modulo ORD_DEPTH.
REQ-016 SHALL keep count unchanged on simultaneous push and pop, including at full.
REQ-017 SHALL implement FSM IDLE (FIFO empty), WAIT (head valid, out register free or draining), HOLD (out register valid, out_rdy low).
REQ-018 SHALL transition IDLE->WAIT one cycle after first push; a head entry is never visible in its push cycle.
REQ-019 SHALL assert px_rdy only for the pipe named by the head entry, only in WAIT, or in HOLD with out_rdy high; the other pipe's rdy is 0.
REQ-020 SHALL, on px_vld && px_rdy, load out register with {px_seq_id, px_data, head pipe}, pop the head, set out_vld next cycle (latency 1).
REQ-021 SHALL sustain one block per cycle when the head pipe is valid and out_rdy stays high.
REQ-022 SHALL hold out_* stable while out_vld && !out_rdy; clear out_vld after acceptance unless reloaded that same cycle.
REQ-023 SHALL leave a non-head pipe's valid result pending (rdy low) until its entry reaches the head.

Reset
REQ-024 SHALL, on rst, zero pointers and count, enter IDLE, drive out_vld, p1_rdy, p2_rdy, ord_full, seq_err low and out_seq_id, out_data, out_pipe to 0.
REQ-025 SHALL discard any FIFO entries and out register contents when rst is asserted mid-operation; no transfer completes in a reset cycle.

Configuration
REQ-026 SHALL, with CR_HUF_COMP_HTB_ORD_CHK_EN defined, store seq_id per entry and set seq_err on transfer where px_seq_id != head seq_id, or on disp_vld while ord_full.
REQ-027 SHALL, without CR_HUF_COMP_HTB_ORD_CHK_EN, omit FIFO seq_id storage and tie seq_err to 0; data path unchanged.

Structure
REQ-028 SHALL place the order-entry struct {pipe, seq_id} and the FSM state enum in cr_huf_compPKG.
REQ-029 SHALL implement the order FIFO as sub-module cr_huf_comp_htb_ord_fifo (push/pop/full/empty/head).

Verification
REQ-030 Dispatch pipe1 seq 5, pipe2 seq 6; p2 returns first -> p2_rdy low; after p1 returns, out seq 5 then 6, out_pipe 0 then 1.
REQ-031 Four dispatches alternating pipes, both pipes valid, out_rdy=1 -> four outputs on four consecutive cycles, ord_full high after 4th push.
REQ-032 FIFO full, 5th disp_vld with pop same cycle -> dispatch dropped, count stays 3 after pop, seq_err=1 only with CHK_EN.
REQ-033 out_rdy held low 3 cycles with out_vld high -> out_data/out_seq_id constant, head pipe rdy low, no pop.
REQ-034 Head expects seq 7, pipe returns seq 9 -> seq_err rises next cycle and stays high with CHK_EN; 0 without.
REQ-035 rst asserted with 2 entries queued and out_vld high -> next cycle out_vld=0, ord_full=0, state IDLE, later results ignored.

Source files
------------

// File: rtl/cr_huf_comp_htb_short_ord_pkg.sv
// Shared types for the short-block tree result reorder path: order-FIFO entry and FSM state.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

package cr_huf_compPKG;

  typedef struct packed {
    logic                              pipe;
    logic [`CREOLE_HC_SEQID_WIDTH-1:0] seq_id;
  } ord_ent_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } ord_st_t;

endpackage

// File: rtl/cr_huf_comp_htb_ord_fifo.sv
// Dispatch-order FIFO; head/empty/full reflect registered state, so a pushed entry appears next cycle.
// Push at full is accepted only together with a pop, leaving the count unchanged.
module cr_huf_comp_htb_ord_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_dat,
  output logic [W-1:0]             o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_cnt
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_cnt   = r_cnt;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_rd    = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_rd);

  always_ff @(posedge clk) begin
    if (w_wr && !rst) r_mem[r_wr_ptr] <= i_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_rd)      r_cnt <= r_cnt + 1'b1;
      else if (w_rd && !w_wr) r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/cr_huf_comp_htb_short_ord.sv
// Merges two tree-builder result pipes back into dispatch order; 1-cycle latency, out_rdy low stalls the head pipe.
// Define CR_HUF_COMP_HTB_ORD_CHK_EN to store seq_ids and flag ordering/overflow errors on seq_err.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

module cr_huf_comp_htb_short_ord
  import cr_huf_compPKG::*;
#(
  parameter int DATA_W    = 64,
  parameter int ORD_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              disp_vld,
  input  logic                              disp_pipe,
  input  logic [`CREOLE_HC_SEQID_WIDTH-1:0] disp_seq_id,
  output logic                              ord_full,
  input  logic                              p1_vld,
  output logic                              p1_rdy,
  input  logic [`CREOLE_HC_SEQID_WIDTH-1:0] p1_seq_id,
  input  logic [DATA_W-1:0]                 p1_data,
  input  logic                              p2_vld,
  output logic                              p2_rdy,
  input  logic [`CREOLE_HC_SEQID_WIDTH-1:0] p2_seq_id,
  input  logic [DATA_W-1:0]                 p2_data,
  output logic                              out_vld,
  input  logic                              out_rdy,
  output logic [`CREOLE_HC_SEQID_WIDTH-1:0] out_seq_id,
  output logic [DATA_W-1:0]                 out_data,
  output logic                              out_pipe,
  output logic                              seq_err
);
  localparam int CW = $clog2(ORD_DEPTH) + 1;
  localparam int SW = `CREOLE_HC_SEQID_WIDTH;
`ifdef CR_HUF_COMP_HTB_ORD_CHK_EN
  localparam int EW = $bits(ord_ent_t);
`else
  localparam int EW = 1;
`endif

  logic              w_push, w_pop, w_empty, w_full;
  logic [CW-1:0]     w_cnt, w_cnt_nxt;
  logic [EW-1:0]     w_push_dat, w_head;
  logic              w_head_pipe, w_rdy_ok, w_xfer1, w_xfer2, w_out_vld_nxt;
  logic [SW-1:0]     w_sel_seq;
  logic [DATA_W-1:0] w_sel_data;
  ord_st_t           r_state, w_state_nxt;
  logic              r_out_vld, r_out_pipe;
  logic [SW-1:0]     r_out_seq;
  logic [DATA_W-1:0] r_out_data;

  assign w_push   = disp_vld && !w_full && !rst;
  assign ord_full = w_full;

  cr_huf_comp_htb_ord_fifo #(.W(EW), .DEPTH(ORD_DEPTH)) u_ord_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   (w_push_dat),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_cnt   (w_cnt)
  );

`ifdef CR_HUF_COMP_HTB_ORD_CHK_EN
  ord_ent_t w_push_ent, w_head_ent;
  logic     r_seq_err;
  assign w_push_ent  = '{pipe: disp_pipe, seq_id: disp_seq_id};
  assign w_push_dat  = w_push_ent;
  assign w_head_ent  = w_head;
  assign w_head_pipe = w_head_ent.pipe;
  assign seq_err     = r_seq_err;

  always_ff @(posedge clk) begin
    if (rst) r_seq_err <= 1'b0;
    else if ((w_pop && (w_sel_seq != w_head_ent.seq_id)) || (disp_vld && w_full))
      r_seq_err <= 1'b1;
  end
`else
  logic w_unused_seq;
  assign w_unused_seq = ^disp_seq_id;
  assign w_push_dat   = disp_pipe;
  assign w_head_pipe  = w_head[0];
  assign seq_err      = 1'b0;
`endif

  // Only the pipe owning the oldest outstanding dispatch may hand over a result.
  assign w_rdy_ok   = !rst && !w_empty &&
                      ((r_state == ST_WAIT) || ((r_state == ST_HOLD) && out_rdy));
  assign p1_rdy     = w_rdy_ok && !w_head_pipe;
  assign p2_rdy     = w_rdy_ok && w_head_pipe;
  assign w_xfer1    = p1_vld && p1_rdy;
  assign w_xfer2    = p2_vld && p2_rdy;
  assign w_pop      = w_xfer1 || w_xfer2;
  assign w_sel_seq  = w_head_pipe ? p2_seq_id : p1_seq_id;
  assign w_sel_data = w_head_pipe ? p2_data : p1_data;

  assign w_cnt_nxt     = w_cnt + CW'(w_push) - CW'(w_pop);
  assign w_out_vld_nxt = w_pop || (r_out_vld && !out_rdy);

  always_comb begin
    w_state_nxt = r_state;
    if (w_cnt_nxt == '0)   w_state_nxt = ST_IDLE;
    else if (w_out_vld_nxt) w_state_nxt = ST_HOLD;
    else                    w_state_nxt = ST_WAIT;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld  <= 1'b0;
      r_out_pipe <= 1'b0;
      r_out_seq  <= '0;
      r_out_data <= '0;
    end else if (w_pop) begin
      r_out_vld  <= 1'b1;
      r_out_pipe <= w_head_pipe;
      r_out_seq  <= w_sel_seq;
      r_out_data <= w_sel_data;
    end else if (out_rdy) begin
      r_out_vld  <= 1'b0;
    end
  end

  assign out_vld    = r_out_vld;
  assign out_pipe   = r_out_pipe;
  assign out_seq_id = r_out_seq;
  assign out_data   = r_out_data;
endmodule
